// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the UART receive monitor.
// UART_MON_PARITY_EN adds the PARITY state (8E1 framing); default is 8N1.
package uart_mon_pkg;

`ifdef UART_MON_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_t;
`endif

   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_chan.sv
// One UART receive channel: input synchroniser, frame FSM, baud timer, holding register.
// UART_MON_PARITY_EN inserts an even-parity check between the data and stop bits.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synced line
// START  | half-bit wait, confirm start bit still low
// DATA   | 8 samples at DIV spacing, LSB first
// PARITY | even-parity sample (parity build only)
// STOP   | stop-bit sample, deliver or flag the byte
module uart_rx_chan
   import uart_mon_pkg::*;
#(
   parameter int DIV = 108
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       clr,
   input  logic       take,
   output logic       pending,
   output logic [7:0] data,
   output logic       frame_err,
   output logic       overflow
);

   localparam int            CW       = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_TOP  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV - 1 - DIV / 2);

   rx_state_t     state;
   logic          rx_s1, rx_s2, rx_prev;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          tick;

   assign tick = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_prev   <= 1'b1;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         pending   <= 1'b0;
         data      <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         cnt     <= tick ? CNT_TOP : cnt - CW'(1);

         // clear first so a same-cycle error below overrides it
         if (clr) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
         end
         if (take)
            pending <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  state <= ST_START;
                  cnt   <= CNT_TOP;
               end
            end
            ST_START: begin
               if (cnt == CNT_HALF) begin
                  cnt     <= CNT_TOP;
                  bit_idx <= '0;
                  state   <= rx_s2 ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  shreg   <= {rx_s2, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     cnt <= CNT_TOP;
`ifdef UART_MON_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_MON_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  cnt <= CNT_TOP;
                  if (rx_s2 != ^shreg) begin
                     frame_err <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     state <= ST_STOP;
                  end
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  cnt   <= CNT_TOP;
                  state <= ST_IDLE;
                  if (!rx_s2) begin
                     frame_err <= 1'b1;
                  end else if (pending && !take) begin
                     overflow <= 1'b1;
                  end else begin
                     pending <= 1'b1;
                     data    <= shreg;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_monitor.sv
// Multi-channel UART receive monitor: per-channel receivers, round-robin arbiter, shared FIFO.
// Define UART_MON_PARITY_EN for 8E1 framing; default build is 8N1.
module uart_rx_monitor
   import uart_mon_pkg::*;
#(
   parameter int NUM_CH      = 1,
   parameter int CLK_FREQ_HZ = 12_500_000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             i_rx,
   output logic [7:0]                    o_data,
   output logic [ch_width(NUM_CH)-1:0]   o_ch,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [NUM_CH-1:0]             o_frame_err,
   output logic [NUM_CH-1:0]             o_overflow,
   input  logic                          i_clr
);

   localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
   localparam int CHW = ch_width(NUM_CH);
   localparam int AW  = $clog2(FIFO_DEPTH);

   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] take;
   logic [7:0]        chan_data [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      uart_rx_chan #(.DIV(DIV)) u_chan (
         .clk       (clk),
         .rst       (rst),
         .rx        (i_rx[g]),
         .clr       (i_clr),
         .take      (take[g]),
         .pending   (pend[g]),
         .data      (chan_data[g]),
         .frame_err (o_frame_err[g]),
         .overflow  (o_overflow[g])
      );
   end

   logic [AW:0]    wptr, rptr;
   logic [7:0]     mem_data [FIFO_DEPTH];
   logic [CHW-1:0] mem_ch   [FIFO_DEPTH];
   logic           full, empty, pop, push;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop   = !empty && i_ready;

   assign o_valid = !empty;
   assign o_data  = mem_data[rptr[AW-1:0]];
   assign o_ch    = mem_ch[rptr[AW-1:0]];

   logic [CHW-1:0] rr_ptr, grant_idx, lo_idx, hi_idx;
   logic           lo_vld, hi_vld;

   // lowest pending at or above rr_ptr, else lowest pending overall
   always_comb begin
      lo_idx = '0;
      hi_idx = '0;
      lo_vld = 1'b0;
      hi_vld = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pend[i]) begin
            lo_idx = CHW'(i);
            lo_vld = 1'b1;
            if (i >= int'(rr_ptr)) begin
               hi_idx = CHW'(i);
               hi_vld = 1'b1;
            end
         end
      end
      grant_idx = hi_vld ? hi_idx : lo_idx;
      push      = lo_vld && (!full || pop);
      take      = '0;
      for (int i = 0; i < NUM_CH; i++)
         take[i] = push && (grant_idx == CHW'(i));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr   <= '0;
         rptr   <= '0;
         rr_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_ch[i]   <= '0;
         end
      end else begin
         if (push) begin
            mem_data[wptr[AW-1:0]] <= chan_data[grant_idx];
            mem_ch[wptr[AW-1:0]]   <= grant_idx;
            wptr                   <= wptr + (AW+1)'(1);
            rr_ptr <= (grant_idx == CHW'(NUM_CH - 1)) ? '0 : grant_idx + CHW'(1);
         end
         if (pop)
            rptr <= rptr + (AW+1)'(1);
      end
   end

endmodule
